// File: rtl/sap1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_pkg
//  Description : Shared SAP-1 definitions: default RAM geometry and the
//                program-loader state encoding.
//                PROG_LOADER_CHECKSUM_EN adds the CSUM and ERROR states.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap1_pkg;

    localparam int c_ADDR_WIDTH = 4;    // 16-byte program RAM
    localparam int c_DATA_WIDTH = 8;    // byte-wide RAM words

    // Fixed codes so that state values stay the same with or without the
    // checksum states compiled in.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLEAR   = 4'd1,
        ST_LOAD    = 4'd2,
        ST_WRITE   = 4'd3,
        ST_RELEASE = 4'd5,
        ST_RUN     = 4'd6,
        ST_HALTED  = 4'd7
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        ST_CSUM    = 4'd4,
        ST_ERROR   = 4'd8
`endif
    } state_t;

endpackage : sap1_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Streams a program into SAP-1 RAM through the front-panel
//                programming port, then releases the CPU to run until halt.
//                Optional macro PROG_LOADER_CHECKSUM_EN: a trailing checksum
//                byte must bring the byte sum to zero before the CPU runs.
//  Ports       : sysclk, reset_n (sync, active-low)
//                start, abort         - control requests
//                in_valid/in_data/in_ready - program byte stream
//                halt                 - SAP-1 halt flag
//                fp_prog, fp_write, fp_adr, fp_data, fp_clear - front panel
//                run_en               - SAP-1 clock enable
//                busy, done, err      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import sap1_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  sysclk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  halt,
    output logic                  fp_prog,
    output logic                  fp_write,
    output logic [ADDR_WIDTH-1:0] fp_adr,
    output logic [DATA_WIDTH-1:0] fp_data,
    output logic                  fp_clear,
    output logic                  run_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_fp_data;
    logic                  w_restart;      // entering CLEAR: zero addr/acc
    logic                  w_load_accept;  // program byte consumed in LOAD
    logic                  w_addr_inc;     // advance to next RAM location

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_csum_sum;

    // Modulo 2**DATA_WIDTH by truncation to the accumulator width.
    assign w_csum_sum = r_acc + in_data;
`endif

    assign fp_adr  = r_addr;
    assign fp_data = r_fp_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. Every output is a pure decode of the
    // current state, so a reset or abort that lands in IDLE silences them
    // from the following cycle without any extra gating.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_restart     = 1'b0;
        w_load_accept = 1'b0;
        w_addr_inc    = 1'b0;
        in_ready      = 1'b0;
        fp_prog       = 1'b0;
        fp_write      = 1'b0;
        fp_clear      = 1'b0;
        run_en        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        err           = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                    w_restart   = 1'b1;
                end
            end
            ST_CLEAR: begin
                fp_clear    = 1'b1;
                fp_prog     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                fp_prog  = 1'b1;
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_accept = 1'b1;
                    w_state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                fp_prog  = 1'b1;
                busy     = 1'b1;
                fp_write = 1'b1;
                if (r_addr != c_ADDR_MAX) begin
                    w_addr_inc  = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    // Address stays at the top location; no wrap.
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_state_nxt = ST_CSUM;
`else
                    w_state_nxt = ST_RELEASE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                fp_prog  = 1'b1;
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (w_csum_sum == '0) ? ST_RELEASE : ST_ERROR;
                end
            end
            ST_ERROR: begin
                err = 1'b1;
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                    w_restart   = 1'b1;
                end
            end
`endif
            ST_RELEASE: begin
                fp_clear    = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                run_en = 1'b1;
                busy   = 1'b1;
                if (halt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                    w_restart   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start, and
        // must not let a byte be consumed on its way out.
        if (abort) begin
            w_state_nxt   = ST_IDLE;
            w_restart     = 1'b0;
            w_load_accept = 1'b0;
            w_addr_inc    = 1'b0;
        end
    end

`ifndef PROG_LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Address counter, data latch and checksum accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_fp_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_acc     <= '0;
`endif
        end else begin
            if (w_restart) begin
                r_addr <= '0;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_load_accept) begin
                r_fp_data <= in_data;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (w_restart) begin
                r_acc <= '0;
            end else if (w_load_accept) begin
                r_acc <= w_csum_sum;
            end
`endif
        end
    end

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Random program images
//                and stall patterns are streamed in; the reference model is
//                the expected RAM image (address n receives byte n) plus the
//                arithmetic checksum rule when PROG_LOADER_CHECKSUM_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          sysclk   = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          halt     = 1'b0;
    logic          in_ready;
    logic          fp_prog;
    logic          fp_write;
    logic [AW-1:0] fp_adr;
    logic [DW-1:0] fp_data;
    logic          fp_clear;
    logic          run_en;
    logic          busy;
    logic          done;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] bytes_q [N];
    int            stall_q [N];

    prog_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .halt     (halt),
        .fp_prog  (fp_prog),
        .fp_write (fp_write),
        .fp_adr   (fp_adr),
        .fp_data  (fp_data),
        .fp_clear (fp_clear),
        .run_en   (run_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        halt     = 1'b0;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
    endtask

    // Two's complement of the byte sum: the value that brings it to zero.
    function automatic logic [DW-1:0] good_csum();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < N; i++) s = s + bytes_q[i];
        return DW'(0) - s;
    endfunction

    // Issues start, then streams bytes_q with stall_q idle cycles before each
    // byte. Expects address n to receive bytes_q[n] in order, then either
    // RELEASE->RUN or ERROR.
    task automatic stream(input logic [DW-1:0] csum, input bit expect_run,
                          input bit check_spacing, input bit rand_halt);
        int  idx = 0;
        int  nwr = 0;
        int  last_wr = -1;
        bit  prev_rel = 1'b0;
        bit  wrote_now;
        bit  csum_sent = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (fp_clear !== 1'b1 || fp_prog !== 1'b1 || busy !== 1'b1 ||
            in_ready !== 1'b0 || fp_adr !== '0)
            $display("FAIL clear_pulse: clear=%b prog=%b busy=%b rdy=%b adr=%0d, required 1 1 1 0 0",
                     fp_clear, fp_prog, busy, in_ready, fp_adr);
        for (int cyc = 0; cyc < 300; cyc++) begin
            wrote_now = 1'b0;
            if (fp_write === 1'b1) begin
                wrote_now = 1'b1;
                n_tests++;
                if (nwr >= N || fp_adr !== AW'(nwr) || fp_data !== bytes_q[nwr % N]) begin
                    n_fail++;
                    $display("FAIL write_%0d: adr=%0d data=%0h, required adr=%0d data=%0h",
                             nwr, fp_adr, fp_data, nwr, bytes_q[nwr % N]);
                end
                if (check_spacing) begin
                    n_tests++;
                    if ((last_wr < 0 && cyc != 2) || (last_wr >= 0 && cyc - last_wr != 2)) begin
                        n_fail++;
                        $display("FAIL write_spacing_%0d: write at cycle %0d, previous %0d, required 2 apart (first at 2)",
                                 nwr, cyc, last_wr);
                    end
                end
                last_wr = cyc;
                nwr++;
            end
            if (run_en === 1'b1 || err === 1'b1) break;
            prev_rel = (fp_clear === 1'b1 && fp_prog === 1'b0 && busy === 1'b1);
            halt = rand_halt ? 1'($urandom_range(0, 1)) : 1'b0;
            if (idx < N) begin
                if (stall_q[idx] > 0) begin
                    // Waiting in LOAD: ready stays up and the address holds.
                    if (!wrote_now && nwr == idx && idx > 0) begin
                        n_tests++;
                        if (in_ready !== 1'b1 || fp_adr !== AW'(idx)) begin
                            n_fail++;
                            $display("FAIL stall_hold: rdy=%b adr=%0d, required rdy=1 adr=%0d",
                                     in_ready, fp_adr, idx);
                        end
                    end
                    stall_q[idx]--;
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    in_data  = bytes_q[idx];
                    if (in_ready === 1'b1) idx++;
                end
            end else if (!csum_sent) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                in_valid = 1'b1;
                in_data  = csum;
                if (in_ready === 1'b1) csum_sent = 1'b1;
`else
                in_valid = 1'b0;
                in_data  = csum;
                csum_sent = 1'b1;
`endif
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        halt     = 1'b0;
        n_tests++;
        if (nwr !== N) begin
            n_fail++;
            $display("FAIL write_count: %0d writes, required %0d", nwr, N);
        end
        if (expect_run) begin
            n_tests++;
            if (run_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || fp_prog !== 1'b0) begin
                n_fail++;
                $display("FAIL run_state: run_en=%b busy=%b done=%b err=%b prog=%b, required 1 1 0 0 0",
                         run_en, busy, done, err, fp_prog);
            end
            n_tests++;
            if (!prev_rel) begin
                n_fail++;
                $display("FAIL release_pulse: cycle before RUN lacked clear=1 prog=0, required RELEASE");
            end
        end else begin
            n_tests++;
            if (err !== 1'b1 || run_en !== 1'b0 || busy !== 1'b0 || fp_prog !== 1'b0) begin
                n_fail++;
                $display("FAIL error_state: err=%b run_en=%b busy=%b prog=%b, required 1 0 0 0",
                         err, run_en, busy, fp_prog);
            end
        end
    endtask

    // Bounded walk up to LOAD at a given address, bytes back to back.
    task automatic load_until(input int target, input string name);
        bit reached = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (in_ready === 1'b1 && fp_adr === AW'(target)) begin
                reached = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        n_tests++;
        if (!reached) begin
            n_fail++;
            $display("FAIL %s: LOAD at address %0d not reached, adr=%0d", name, target, fp_adr);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        halt     = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({fp_prog, fp_write, fp_clear, in_ready, run_en, busy, done, err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: flags=%b, required 00000000",
                     {fp_prog, fp_write, fp_clear, in_ready, run_en, busy, done, err});
        end
        n_tests++;
        if (fp_adr !== '0 || fp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: adr=%0d data=%0h, required 0 0", fp_adr, fp_data);
        end
        reset_n  = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        halt     = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b, required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) begin
            bytes_q[i] = DW'(i);
            stall_q[i] = 0;
        end
        stream(good_csum(), 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_halt_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (run_en !== 1'b1 || fp_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_run: run_en=%b clear=%b, required 1 0", run_en, fp_clear);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_tests++;
        if (run_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL halted: run_en=%b done=%b busy=%b, required 0 1 0", run_en, done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || run_en !== 1'b0) begin
            n_fail++;
            $display("FAIL halted_hold: done=%b run_en=%b, required 1 0", done, run_en);
        end
        for (int i = 0; i < N; i++) begin
            bytes_q[i] = DW'($urandom);
            stall_q[i] = 0;
        end
        stream(good_csum(), 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        go_idle();
        for (int i = 0; i < N; i++) begin
            bytes_q[i] = DW'($urandom);
            stall_q[i] = 0;
        end
        stall_q[3] = 6;   // WRITE cycle of byte 2, then 5 idle LOAD cycles
        stream(good_csum(), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        go_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_until(7, "abort_reach");
        abort    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        abort    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (fp_prog !== 1'b0 || busy !== 1'b0 || fp_write !== 1'b0 ||
            in_ready !== 1'b0 || run_en !== 1'b0 || fp_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wins: prog=%b busy=%b wr=%b rdy=%b run=%b clear=%b, required all 0",
                     fp_prog, busy, fp_write, in_ready, run_en, fp_clear);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || fp_write !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b wr=%b, required 0 0", busy, fp_write);
        end
    endtask

    task automatic test_reset_midload();
        go_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_until(4, "midload_reach");
        in_valid = 1'b1;
        reset_n  = 1'b0;
        tick();
        n_tests++;
        if (fp_write !== 1'b0 || busy !== 1'b0 || fp_adr !== '0 || fp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_midload: wr=%b busy=%b adr=%0d data=%0h, required 0 0 0 0",
                     fp_write, busy, fp_adr, fp_data);
        end
        reset_n  = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (fp_write !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midload_after: wr=%b busy=%b, required 0 0", fp_write, busy);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        go_idle();
        for (int i = 0; i < N; i++) begin
            bytes_q[i] = 8'h01;
            stall_q[i] = 0;
        end
        stream(8'hF0, 1'b1, 1'b0, 1'b0);
        go_idle();
        stream(8'hF1, 1'b0, 1'b0, 1'b0);
        // Restart straight from ERROR.
        stream(8'hF0, 1'b1, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] cs;
        bit            good;
        for (int it = 0; it < 6; it++) begin
            go_idle();
            for (int i = 0; i < N; i++) begin
                bytes_q[i] = DW'($urandom);
                stall_q[i] = $urandom_range(0, 3);
            end
            cs   = good_csum();
            good = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (it % 3 == 2) begin
                cs   = cs + DW'($urandom_range(1, 255));
                good = 1'b0;
            end
`endif
            stream(cs, good, 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_halt_restart();
        test_stall();
        test_abort();
        test_reset_midload();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, RAM address width; the program holds 2**ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port sysclk, input, 1, system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, level sampled each cycle; a request to load and run.
REQ-007 The block SHALL have port abort, input, 1, forces an immediate return to IDLE.
REQ-008 The block SHALL have port in_valid, input, 1, a byte is offered on in_data.
REQ-009 The block SHALL have port in_data, input, DATA_WIDTH, the program byte stream.
REQ-010 The block SHALL have port in_ready, output, 1, the loader accepts a byte this cycle.
REQ-011 The block SHALL have port halt, input, 1, the SAP-1 halt flag.
REQ-012 The block SHALL have ports fp_prog, fp_write (output, 1), fp_adr (output, ADDR_WIDTH) and fp_data (output, DATA_WIDTH), which drive the SAP-1 front-panel programming port.
REQ-013 The block SHALL have port fp_clear, output, 1, a one-cycle clear pulse to the SAP-1.
REQ-014 The block SHALL have port run_en, output, 1, which gates the SAP-1 clken; high only in RUN.
REQ-015 The block SHALL have ports busy, done and err, output, 1 each; they are status flags.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, LOAD, WRITE, CSUM, RELEASE, RUN, HALTED and ERROR.
REQ-017 In IDLE, HALTED or ERROR, start=1 SHALL cause a transition to CLEAR on the next edge, with the address counter and the checksum accumulator reset to 0; start SHALL be ignored in all other states.
REQ-018 CLEAR SHALL last exactly one cycle with fp_clear=1 and fp_prog=1, then go to LOAD.
REQ-019 In LOAD, in_ready SHALL be 1; when in_valid&&in_ready, fp_data SHALL capture in_data, the accumulator SHALL add in_data mod 2**DATA_WIDTH, and the FSM SHALL go to WRITE.
REQ-020 WRITE SHALL last exactly one cycle with fp_write=1 and fp_adr equal to the current address.
REQ-021 Leaving WRITE, if the address is below the maximum the address SHALL increment and the FSM SHALL return to LOAD.
REQ-022 Leaving WRITE at the maximum address, the FSM SHALL go to CSUM when CHECKSUM_EN is defined and to RELEASE otherwise; the address SHALL NOT wrap.
REQ-023 fp_prog SHALL be 1 from CLEAR through CSUM, and 0 in all other states.
REQ-024 fp_write SHALL be 1 only in WRITE, and in_ready SHALL be 1 only in LOAD and CSUM.
REQ-025 RELEASE SHALL last exactly one cycle with fp_prog=0 and fp_clear=1, then go to RUN.
REQ-026 In RUN, run_en SHALL be 1; halt=1 SHALL cause a transition to HALTED next edge, with run_en 0 from HALTED onward.
REQ-027 busy SHALL be 1 in CLEAR through RUN; done SHALL be 1 only in HALTED; err SHALL be 1 only in ERROR.
REQ-028 abort=1 SHALL move any state to IDLE on the next edge, forcing fp_prog, fp_write, run_en and in_ready to 0; when abort and start are both 1, abort SHALL win.
REQ-029 A halt asserted outside RUN SHALL be ignored, and in_valid outside LOAD/CSUM SHALL NOT be consumed.

Reset
REQ-030 When reset_n=0 at a rising edge, the FSM SHALL enter IDLE, and the address, the accumulator, fp_data and all 1-bit outputs SHALL become 0.
REQ-031 Reset mid-load SHALL leave RAM contents undefined and SHALL NOT generate an fp_write pulse.

Configuration
REQ-032 When the macro PROG_LOADER_CHECKSUM_EN is defined, CSUM SHALL accept one extra byte; if accumulator+byte==0 mod 2**DATA_WIDTH the FSM SHALL go to RELEASE, otherwise to ERROR.
REQ-033 When PROG_LOADER_CHECKSUM_EN is undefined, the accumulator and the CSUM and ERROR states SHALL be absent, and err SHALL be tied to 0.

Structure
REQ-034 The state enumeration and the default ADDR_WIDTH/DATA_WIDTH constants SHALL reside in the shared package sap1_pkg.
REQ-035 The FSM, address counter and accumulator SHALL be implemented inline; no sub-module is required.

Verification
REQ-036 Verification SHALL cover: start with 16 bytes 0x00..0x0F streamed back-to-back -> 16 fp_write pulses, with fp_adr=n and fp_data=n, each two cycles apart, then RELEASE and run_en=1.
REQ-037 Verification SHALL cover: in_valid stalled for 5 cycles after byte 3 -> in_ready stays 1, no fp_write occurs, and the address holds at 3.
REQ-038 Verification SHALL cover: in RUN, halt=1 -> run_en=0 and done=1 next cycle; then start=1 -> CLEAR pulse and a reload from address 0.
REQ-039 Verification SHALL cover: abort=1 together with start=1 in LOAD at address 7 -> IDLE next cycle with fp_prog=0 and busy=0.
REQ-040 Verification SHALL cover, with CHECKSUM_EN defined: 16 bytes of 0x01 with checksum 0xF0 -> RUN; with checksum 0xF1 -> ERROR, err=1 and run_en=0.
